// File: rtl/me_operand_loader.sv
// me_operand_loader: assembles a, e, m, m_n and m_prime for me_top from a W-bit valid/ready stream,
// then fires en_pre_me with the job tag and blocks until me_top returns that tag.
module me_operand_loader #(
   parameter int M_SIZE   = 3072,
   parameter int RADIX    = 72,
   parameter int SIZE_LOG = 6,
   parameter int W        = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [W-1:0]                 s_data,
   input  logic                         s_last,
   input  logic [3:0]                   s_num,
   output logic [M_SIZE-1:0]            a,
   output logic [M_SIZE-1:0]            e,
   output logic [M_SIZE-1:0]            m,
   output logic [M_SIZE+1:0]            m_n,
   output logic [RADIX+SIZE_LOG+1:0]    m_prime,
   output logic [3:0]                   num,
   output logic                         en_pre_me,
   input  logic                         me_done,
   input  logic [3:0]                   me_num_out,
   output logic                         busy,
   output logic                         err
);
   localparam int PW = RADIX + SIZE_LOG + 2;
   localparam int NA = (M_SIZE + W - 1) / W;
   localparam int NN = (M_SIZE + 2 + W - 1) / W;
   localparam int NP = (PW + W - 1) / W;
   localparam int L  = 3 * NA + NN + NP;
   localparam int CW = $clog2(L);
   typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic err_n, rdy, wr, at_end;
   assign s_ready   = rdy && (state == IDLE || state == LOAD);
   assign wr        = s_valid && s_ready;
   assign at_end    = cnt == CW'(L - 1);
   assign en_pre_me = state == FIRE;
   assign busy      = state != IDLE;
   // rdy holds s_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
         rdy   <= 1'b0;
         num   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         err   <= err_n;
         rdy   <= 1'b1;
         if (wr && state == IDLE) num <= s_num;
      end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = 1'b0;
      case (state)
         IDLE, LOAD: if (wr) begin
            err_n   = s_last != at_end;
            state_n = err_n ? IDLE : at_end ? FIRE : LOAD;
            cnt_n   = (err_n || at_end) ? '0 : cnt + CW'(1);
         end
         FIRE:    state_n = WAIT;
         WAIT:    state_n = (me_done && me_num_out == num) ? IDLE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   me_field_reg #(.WIDTH(M_SIZE), .N(NA), .BASE(0), .W(W), .CW(CW)) u_a (
      .clk(clk), .rst_n(rst_n), .wr(wr), .cnt(cnt), .s_data(s_data), .q(a));
   me_field_reg #(.WIDTH(M_SIZE), .N(NA), .BASE(NA), .W(W), .CW(CW)) u_e (
      .clk(clk), .rst_n(rst_n), .wr(wr), .cnt(cnt), .s_data(s_data), .q(e));
   me_field_reg #(.WIDTH(M_SIZE), .N(NA), .BASE(2 * NA), .W(W), .CW(CW)) u_m (
      .clk(clk), .rst_n(rst_n), .wr(wr), .cnt(cnt), .s_data(s_data), .q(m));
   me_field_reg #(.WIDTH(M_SIZE + 2), .N(NN), .BASE(3 * NA), .W(W), .CW(CW)) u_mn (
      .clk(clk), .rst_n(rst_n), .wr(wr), .cnt(cnt), .s_data(s_data), .q(m_n));
   me_field_reg #(.WIDTH(PW), .N(NP), .BASE(3 * NA + NN), .W(W), .CW(CW)) u_mp (
      .clk(clk), .rst_n(rst_n), .wr(wr), .cnt(cnt), .s_data(s_data), .q(m_prime));
endmodule

// One operand field: word k lands in bits [k*W +: W], the final word truncated to the field width.
module me_field_reg #(
   parameter int WIDTH = 64,
   parameter int N     = 1,
   parameter int BASE  = 0,
   parameter int W     = 64,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [CW-1:0]    cnt,
   input  logic [W-1:0]     s_data,
   output logic [WIDTH-1:0] q
);
   for (genvar k = 0; k < N; k++) begin : g_w
      localparam int lo = k * W;
      localparam int nb = (WIDTH - lo < W) ? WIDTH - lo : W;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) q[lo +: nb] <= '0;
         else if (wr && cnt == CW'(BASE + k)) q[lo +: nb] <= s_data[nb-1:0];
   end
endmodule

// File: tb/tb_me_operand_loader.sv
// tb_me_operand_loader: random jobs streamed into the loader; a scoreboard queue of expected
// fires/errors is checked by a monitor whenever en_pre_me or err pulses.
module tb_me_operand_loader;
   localparam int M_SIZE = 3072, RADIX = 72, SIZE_LOG = 6, W = 64;
   localparam int PW = RADIX + SIZE_LOG + 2;
   localparam int NA = (M_SIZE + W - 1) / W;
   localparam int NN = (M_SIZE + 2 + W - 1) / W;
   localparam int NP = (PW + W - 1) / W;
   localparam int L  = 3 * NA + NN + NP;
   typedef logic [NN*W-1:0] big_t;
   typedef struct {big_t a, e, m, mn, mp; logic [3:0] num; int cyc;} exp_t;

   logic clk = 1'b0, rst_n;
   logic s_valid, s_ready, s_last, me_done, en_pre_me, busy, err;
   logic [W-1:0] s_data;
   logic [3:0] s_num, num, me_num_out;
   logic [M_SIZE-1:0] a, e, m;
   logic [M_SIZE+1:0] m_n;
   logic [PW-1:0] m_prime;
   int total = 0, bad = 0, cyc = 0;
   exp_t fire_q[$];
   int err_q[$];
   exp_t mon_ex;
   int mon_ec;
   big_t fa, fe, fm, fmn, fmp;
   logic [3:0] tg;
   bit tog;

   me_operand_loader #(.M_SIZE(M_SIZE), .RADIX(RADIX), .SIZE_LOG(SIZE_LOG), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .s_num(s_num), .a(a), .e(e), .m(m), .m_n(m_n), .m_prime(m_prime),
      .num(num), .en_pre_me(en_pre_me), .me_done(me_done), .me_num_out(me_num_out),
      .busy(busy), .err(err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
      end
   endtask

   task automatic chk_wide(input string nm, input big_t got, input big_t expv);
      int k;
      total++;
      if (got !== expv) begin
         bad++;
         k = 0;
         for (int i = NN - 1; i >= 0; i--) if (got[i*W +: W] !== expv[i*W +: W]) k = i;
         $display("FAIL %s word %0d got=%h exp=%h", nm, k, got[k*W +: W], expv[k*W +: W]);
      end
   endtask

   function automatic big_t trunc(input big_t v, input int width);
      return v & ((big_t'(1) << width) - big_t'(1));
   endfunction

   function automatic logic [W-1:0] word_at(input int i);
      if (i < NA) return fa[i*W +: W];
      if (i < 2 * NA) return fe[(i-NA)*W +: W];
      if (i < 3 * NA) return fm[(i-2*NA)*W +: W];
      if (i < 3 * NA + NN) return fmn[(i-3*NA)*W +: W];
      return fmp[(i-3*NA-NN)*W +: W];
   endfunction

   task automatic rand_fields();
      for (int i = 0; i < NN; i++) begin
         fa[i*W +: W]  = W'({$urandom, $urandom});
         fe[i*W +: W]  = W'({$urandom, $urandom});
         fm[i*W +: W]  = W'({$urandom, $urandom});
         fmn[i*W +: W] = W'({$urandom, $urandom});
         fmp[i*W +: W] = W'({$urandom, $urandom});
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 0);
      chk({tag, "_en_pre_me"}, 64'(en_pre_me), 0);
      chk({tag, "_err"}, 64'(err), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_num"}, 64'(num), 0);
      chk_wide({tag, "_a"}, big_t'(a), '0);
      chk_wide({tag, "_e"}, big_t'(e), '0);
      chk_wide({tag, "_m"}, big_t'(m), '0);
      chk_wide({tag, "_m_n"}, big_t'(m_n), '0);
      chk_wide({tag, "_m_prime"}, big_t'(m_prime), '0);
   endtask

   task automatic mid_reset();
      s_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", 64'(s_ready), 1);
      chk("post_rst_busy", 64'(busy), 0);
   endtask

   task automatic send_job(input logic [3:0] tag, input bit tg_valid, input int bad_at, input int rst_at);
      exp_t ex;
      int n;
      for (int i = 0; i < L; i++) begin
         if (i == rst_at) begin
            mid_reset();
            return;
         end
         if (tg_valid && i > 0) begin
            s_valid = 1'b0;
            @(negedge clk);
         end
         s_valid = 1'b1;
         s_data = word_at(i);
         s_last = (i == L - 1) || (i == bad_at);
         s_num = (i == 0) ? tag : 4'($urandom);
         me_done = 1'($urandom);
         me_num_out = tag;
         n = 0;
         while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout word %0d got=0 exp=1", i);
            s_valid = 1'b0;
            me_done = 1'b0;
            return;
         end
         if (i == L - 1) begin
            ex.a = trunc(fa, M_SIZE);
            ex.e = trunc(fe, M_SIZE);
            ex.m = trunc(fm, M_SIZE);
            ex.mn = trunc(fmn, M_SIZE + 2);
            ex.mp = trunc(fmp, PW);
            ex.num = tag;
            ex.cyc = cyc + 1;
            fire_q.push_back(ex);
         end
         if (i == bad_at) err_q.push_back(cyc + 1);
         @(negedge clk);
         if (i == bad_at) begin
            s_valid = 1'b0;
            s_last = 1'b0;
            me_done = 1'b0;
            chk("err_busy", 64'(busy), 0);
            chk("err_s_ready", 64'(s_ready), 1);
            return;
         end
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      me_done = 1'b0;
   endtask

   task automatic wait_done(input logic [3:0] tag);
      @(negedge clk);
      chk("wait_s_ready", 64'(s_ready), 0);
      chk("wait_busy", 64'(busy), 1);
      me_done = 1'b1;
      me_num_out = tag ^ 4'h6;
      @(negedge clk);
      chk("wrong_tag_busy", 64'(busy), 1);
      chk("wrong_tag_s_ready", 64'(s_ready), 0);
      me_num_out = tag;
      @(negedge clk);
      me_done = 1'b0;
      chk("done_s_ready", 64'(s_ready), 1);
      chk("done_busy", 64'(busy), 0);
      chk("num_hold", 64'(num), 64'(tag));
   endtask

   always @(negedge clk) begin
      if (en_pre_me === 1'b1) begin
         if (fire_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_en_pre_me at cycle %0d got=1 exp=0", cyc);
         end else begin
            mon_ex = fire_q.pop_front();
            chk("fire_cycle", 64'(cyc), 64'(mon_ex.cyc));
            chk("num", 64'(num), 64'(mon_ex.num));
            chk_wide("a", big_t'(a), mon_ex.a);
            chk_wide("e", big_t'(e), mon_ex.e);
            chk_wide("m", big_t'(m), mon_ex.m);
            chk_wide("m_n", big_t'(m_n), mon_ex.mn);
            chk_wide("m_prime", big_t'(m_prime), mon_ex.mp);
         end
      end
      if (err === 1'b1) begin
         if (err_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_err at cycle %0d got=1 exp=0", cyc);
         end else begin
            mon_ec = err_q.pop_front();
            chk("err_cycle", 64'(cyc), 64'(mon_ec));
         end
      end
   end

   initial begin
      #1_000_000;
      total++;
      bad++;
      $display("FAIL watchdog at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_last = 1'b0;
      s_num = '0;
      me_done = 1'b0;
      me_num_out = '0;
      #12 chk_all_zero("reset");
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("first_s_ready", 64'(s_ready), 1);
      rand_fields();
      fe = big_t'(8'hAE);
      send_job(4'd5, 1'b0, -1, -1);
      wait_done(4'd5);
      send_job(4'd5, 1'b1, -1, -1);
      wait_done(4'd5);
      rand_fields();
      send_job(4'd9, 1'b0, 100, -1);
      send_job(4'd2, 1'b0, -1, -1);
      wait_done(4'd2);
      rand_fields();
      fmn[48*W +: W] = '1;
      fmp[W +: W] = '1;
      send_job(4'd11, 1'b1, -1, -1);
      wait_done(4'd11);
      rand_fields();
      send_job(4'd4, 1'b0, -1, 120);
      rand_fields();
      send_job(4'd7, 1'b0, -1, -1);
      wait_done(4'd7);
      repeat (3) begin
         rand_fields();
         tg = 4'($urandom);
         tog = 1'($urandom);
         send_job(tg, tog, -1, -1);
         wait_done(tg);
      end
      repeat (4) @(negedge clk);
      chk("pending_fires", 64'(fire_q.size()), 0);
      chk("pending_errs", 64'(err_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/me_operand_loader.md
Name: me_operand_loader

Overview:
- Upstream feeder for me_top.
- Accepts one modular-exponentiation job as a narrow valid/ready word stream and assembles the wide operands a, e, m, m_n and m_prime from it.
- Fires a single-cycle en_pre_me with a job tag on num, then blocks until me_top reports done with the matching num_out.
- Replaces hand-driven wide operand buses with a host/DMA-friendly interface.

Parameters:
- M_SIZE, 3072, operand width of a, e, m.
- RADIX, 72, radix width used by me_top.
- SIZE_LOG, 6, log term used by me_top; m_prime width = RADIX+SIZE_LOG+2.
- W, 64, stream word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  W  stream word, little-endian within each field.
- s_last  in  1  marks the final word of a job.
- s_num  in  4  job tag, sampled with the first word of a job.
- a  out  M_SIZE  operand a to me_top.
- e  out  M_SIZE  exponent to me_top.
- m  out  M_SIZE  modulus to me_top.
- m_n  out  M_SIZE+2  precomputed modulus term to me_top.
- m_prime  out  RADIX+SIZE_LOG+2  Montgomery constant to me_top.
- num  out  4  job tag to me_top.
- en_pre_me  out  1  one-cycle start pulse to me_top.
- me_done  in  1  me_top done.
- me_num_out  in  4  tag returned by me_top.
- busy  out  1  a job is loading, firing or in flight.
- err  out  1  one-cycle pulse on framing error.

Behaviour:
- Word counts:
  - NA = ceil(M_SIZE/W), 48 at defaults.
  - NN = ceil((M_SIZE+2)/W), 49.
  - NP = ceil((RADIX+SIZE_LOG+2)/W), 2.
  - Job length L = 3*NA+NN+NP, 195.
- Field order: a, e, m, m_n, m_prime. Word k of a field fills bits [k*W +: W].
- Bits of the last word of a field beyond the field width are discarded (m_n keeps bits [1:0] of word 48; m_prime keeps [15:0] of word 1).
- A word transfers when s_valid && s_ready.
- States:
  - IDLE: s_ready=1, word counter=0. The first transfer captures s_num into num and goes to LOAD.
  - LOAD: s_ready=1. Each transfer writes the addressed slice and increments a 0..L-1 counter; the field is derived from the counter.
    - Transfer at index L-1 with s_last=1 goes to FIRE.
    - s_last=1 at any index < L-1, or s_last=0 at L-1: err=1 for one cycle, counter cleared, go to IDLE, no en_pre_me.
    - A 1-word job (L==1) is not supported. The first word with s_last=1 is an error.
  - FIRE: s_ready=0, en_pre_me=1 for exactly this cycle. en_pre_me rises the cycle after the final word is accepted. Go to WAIT.
  - WAIT: s_ready=0. me_done=1 && me_num_out==num returns to IDLE on the next edge. me_done with a mismatched tag is ignored.
- busy = (state != IDLE), or equivalently state in LOAD/FIRE/WAIT.
- Operand and num registers change only on accepted words. They are held stable through FIRE and WAIT, and after return to IDLE until the next job's words overwrite them.
- Operand registers are not cleared between jobs. Every bit is rewritten by a complete job.
- me_done asserted while in IDLE/LOAD/FIRE is ignored.
- Reset (asynchronous, any state):
  - Outputs to 0: a, e, m, m_n, m_prime, num, en_pre_me, err, busy.
  - s_ready=0 during reset, then 1 from the first edge after release.
  - State returns to IDLE. A partially loaded job is lost and no en_pre_me is produced.
- s_valid low mid-job stalls without a timeout. The counter is held.

Test Plan:
- Full job, tag 5, s_valid continuously high: a=0x5537b809…5531, e=0xAE, m=0xdc85…d004, m_n=0x3237…fffc, m_prime=0x4a4c0ccb4cb4e139f56b, 195 words. Required: exactly one en_pre_me pulse one cycle after word 194 is accepted, all buses bit-exact, num=5, s_ready=0 until me_done with num_out=5.
- Same job with s_valid toggled 1/0 every cycle. Required: identical operands, en_pre_me one cycle after the final word, no err.
- s_last asserted on word 100. Required: err pulse at the next edge, no en_pre_me, state IDLE. The following clean job with tag 2 fires normally with num=2.
- In WAIT, drive me_done=1 with me_num_out=3 while num=5. Required: stays in WAIT, s_ready=0. Then me_num_out=5 with me_done=1 returns to IDLE and s_ready=1 next cycle.
- Top-bit masking: m_n word 48 = 0xFFFF_FFFF_FFFF_FFFF, m_prime word 1 = 0xFFFF_FFFF_FFFF_FFFF. Required: m_n[3073:3072]=2'b11, m_prime[79:64]=16'hFFFF, no bits outside the field change.
- rst_n pulsed low for 3 ns at word 120. Required: all outputs 0 immediately (asynchronous), no en_pre_me. The next full job with tag 7 loads and fires correctly.
